// File: rtl/bsr_chain_router.sv
// Scan-in router: steers TDI and DR strobes to one of CHAIN_NUM boundary-scan chains; owns the chain-select register.
// Latency: per-chain outputs are combinational from the registered sel; a new sel is visible one TCK after update_dr.
// Backpressure: none; the TAP paces every transfer and each strobe is acted on in the TCK cycle it is presented.
//
// Ports:
//   tck, trst_n           JTAG test clock (rising edge) and asynchronous active-low test reset
//   tdi                   serial test data in
//   capture_dr/shift_dr/update_dr   TAP DR state levels
//   sel_dr_en             CHAIN_SELECT instruction active (select register owns the DR path)
//   bsr_dr_en             boundary-scan instruction active (route to the selected chain)
//   sel_so                select shift register serial out, to the TDO mux
//   sel                   active chain index, to the scan-out mux
//   sel_err               last select update was rejected
//   bsr_si/bsr_shift_en/bsr_capture_en/bsr_update_en   per-chain serial in and enables
module bsr_chain_router #(
    parameter int CHAIN_NUM = 2,
    parameter int SEL_WIDTH = (CHAIN_NUM > 1) ? $clog2(CHAIN_NUM) : 1
) (
    input  logic                 tck,
    input  logic                 trst_n,
    input  logic                 tdi,
    input  logic                 capture_dr,
    input  logic                 shift_dr,
    input  logic                 update_dr,
    input  logic                 sel_dr_en,
    input  logic                 bsr_dr_en,
    output logic                 sel_so,
    output logic [SEL_WIDTH-1:0] sel,
    output logic                 sel_err,
    output logic [CHAIN_NUM-1:0] bsr_si,
    output logic [CHAIN_NUM-1:0] bsr_shift_en,
    output logic [CHAIN_NUM-1:0] bsr_capture_en,
    output logic [CHAIN_NUM-1:0] bsr_update_en
);

    // The bit counter must be able to reach SEL_WIDTH+1 so that an over-long
    // shift stays distinguishable from an exact-length one.
    localparam int                    CNT_WIDTH = $clog2(SEL_WIDTH + 2);
    localparam logic [CNT_WIDTH-1:0]  CNT_FULL  = CNT_WIDTH'(SEL_WIDTH);
    localparam logic [CNT_WIDTH-1:0]  CNT_SAT   = CNT_WIDTH'(SEL_WIDTH + 1);
    // One extra bit so CHAIN_NUM == 2**SEL_WIDTH is representable.
    localparam logic [SEL_WIDTH:0]    SEL_LIMIT = (SEL_WIDTH + 1)'(CHAIN_NUM);

    logic [SEL_WIDTH-1:0] sr;
    logic [CNT_WIDTH-1:0] cnt;
    logic [SEL_WIDTH-1:0] sr_shift;
    logic                 cap_s;
    logic                 sh_s;
    logic                 up_s;
    logic                 upd_ok;
    logic                 route_en;

    // A conforming TAP never raises two strobes together; if it does,
    // capture wins over shift, and shift wins over update.
    assign cap_s = capture_dr;
    assign sh_s  = shift_dr & ~capture_dr;
    assign up_s  = update_dr & ~capture_dr & ~shift_dr;

    // LSB leaves first, TDI enters at the MSB. Written as shifts so the
    // single-bit case needs no special handling.
    assign sr_shift = (sr >> 1) | (SEL_WIDTH'(tdi) << (SEL_WIDTH - 1));

    // Only an exact-length load of an existing chain index is accepted.
    assign upd_ok = (cnt == CNT_FULL) && ({1'b0, sr} < SEL_LIMIT);

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            sel     <= '0;
            sr      <= '0;
            cnt     <= '0;
            sel_err <= 1'b0;
        end else if (sel_dr_en) begin
            if (cap_s) begin
                sr  <= sel;
                cnt <= '0;
            end else if (sh_s) begin
                sr <= sr_shift;
                if (cnt != CNT_SAT) begin
                    cnt <= cnt + 1'b1;
                end
            end else if (up_s) begin
                if (upd_ok) begin
                    sel     <= sr;
                    sel_err <= 1'b0;
                end else begin
                    sel_err <= 1'b1;
                end
            end
        end
    end

    assign sel_so = sel_dr_en & sr[0];

    // The select instruction owns the DR path, so it silences every chain.
    assign route_en = bsr_dr_en & ~sel_dr_en;

    // Decode from registered sel and TAP levels only: no glitches from
    // in-flight select shifting reach the chains.
    always_comb begin
        bsr_si         = '0;
        bsr_shift_en   = '0;
        bsr_capture_en = '0;
        bsr_update_en  = '0;
        if (route_en) begin
            for (int i = 0; i < CHAIN_NUM; i++) begin
                if (sel == SEL_WIDTH'(i)) begin
                    bsr_si[i]         = tdi;
                    bsr_shift_en[i]   = sh_s;
                    bsr_capture_en[i] = cap_s;
                    bsr_update_en[i]  = up_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_bsr_chain_router.sv
module tb_bsr_chain_router;

    logic       tck = 1'b0;
    logic       trst_n;
    logic       tdi;
    logic       capture_dr;
    logic       shift_dr;
    logic       update_dr;
    logic       sel_dr_en;
    logic       bsr_dr_en;
    logic       sel_so;
    logic [1:0] sel;
    logic       sel_err;
    logic [2:0] bsr_si;
    logic [2:0] bsr_shift_en;
    logic [2:0] bsr_capture_en;
    logic [2:0] bsr_update_en;

    int passed = 0;
    int total  = 0;

    bsr_chain_router #(.CHAIN_NUM(3)) dut (
        .tck            (tck),
        .trst_n         (trst_n),
        .tdi            (tdi),
        .capture_dr     (capture_dr),
        .shift_dr       (shift_dr),
        .update_dr      (update_dr),
        .sel_dr_en      (sel_dr_en),
        .bsr_dr_en      (bsr_dr_en),
        .sel_so         (sel_so),
        .sel            (sel),
        .sel_err        (sel_err),
        .bsr_si         (bsr_si),
        .bsr_shift_en   (bsr_shift_en),
        .bsr_capture_en (bsr_capture_en),
        .bsr_update_en  (bsr_update_en)
    );

    always #5 tck = ~tck;

    // in  = {capture_dr, shift_dr, update_dr, sel_dr_en, bsr_dr_en, tdi}
    // st  = {sel_so, sel[1:0], sel_err}   seen before the rising edge
    // vec = {bsr_si, bsr_shift_en, bsr_capture_en, bsr_update_en}
    typedef struct packed {
        logic [5:0]  in;
        logic [3:0]  st;
        logic [11:0] vec;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [5:0] i, input logic [3:0] s, input logic [11:0] v);
        vec_t e;
        e.in  = i;
        e.st  = s;
        e.vec = v;
        tbl.push_back(e);
    endtask

    task automatic drive(input logic [5:0] i);
        {capture_dr, shift_dr, update_dr, sel_dr_en, bsr_dr_en, tdi} = i;
    endtask

    task automatic check(input string name, input logic [15:0] exp);
        logic [15:0] act;
        act = {sel_so, sel, sel_err, bsr_si, bsr_shift_en, bsr_capture_en, bsr_update_en};
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got so/sel/err=%b si=%b sh=%b cap=%b upd=%b, want so/sel/err=%b si=%b sh=%b cap=%b upd=%b",
                     name, act[15:12], act[11:9], act[8:6], act[5:3], act[2:0],
                     exp[15:12], exp[11:9], exp[8:6], exp[5:3], exp[2:0]);
        end else begin
            passed++;
        end
    endtask

    // Drive between edges, sample just before the next rising edge.
    task automatic step(input string name, input logic [5:0] i, input logic [15:0] exp);
        @(negedge tck);
        drive(i);
        #3;
        check(name, exp);
    endtask

    initial begin
        trst_n = 1'b0;
        drive(6'b000000);

        // Set chain 2: shift 0 then 1, LSB first.
        add(6'b100100, 4'b0_00_0, 12'b000_000_000_000);
        add(6'b010100, 4'b0_00_0, 12'b000_000_000_000);
        add(6'b010101, 4'b0_00_0, 12'b000_000_000_000);
        add(6'b001100, 4'b0_00_0, 12'b000_000_000_000);
        add(6'b000000, 4'b0_10_0, 12'b000_000_000_000);
        // Load 3: out of range, rejected.
        add(6'b100100, 4'b0_10_0, 12'b000_000_000_000);
        add(6'b010101, 4'b0_10_0, 12'b000_000_000_000);
        add(6'b010101, 4'b1_10_0, 12'b000_000_000_000);
        add(6'b001100, 4'b1_10_0, 12'b000_000_000_000);
        add(6'b000000, 4'b0_10_1, 12'b000_000_000_000);
        // Load 1 (tdi 1 then 0): accepted, error clears.
        add(6'b100100, 4'b1_10_1, 12'b000_000_000_000);
        add(6'b010101, 4'b0_10_1, 12'b000_000_000_000);
        add(6'b010100, 4'b1_10_1, 12'b000_000_000_000);
        add(6'b001100, 4'b1_10_1, 12'b000_000_000_000);
        add(6'b000000, 4'b0_01_0, 12'b000_000_000_000);
        add(6'b010011, 4'b0_01_0, 12'b010_010_000_000);
        // Three-bit shift: wrong count, rejected.
        add(6'b100100, 4'b1_01_0, 12'b000_000_000_000);
        add(6'b010101, 4'b1_01_0, 12'b000_000_000_000);
        add(6'b010100, 4'b0_01_0, 12'b000_000_000_000);
        add(6'b010100, 4'b1_01_0, 12'b000_000_000_000);
        add(6'b001100, 4'b0_01_0, 12'b000_000_000_000);
        add(6'b000000, 4'b0_01_1, 12'b000_000_000_000);
        // Reload 2 so the zero-bit case starts from a clean error flag.
        add(6'b100100, 4'b0_01_1, 12'b000_000_000_000);
        add(6'b010100, 4'b1_01_1, 12'b000_000_000_000);
        add(6'b010101, 4'b0_01_1, 12'b000_000_000_000);
        add(6'b001100, 4'b0_01_1, 12'b000_000_000_000);
        // Zero-bit shift: capture then update, rejected.
        add(6'b100100, 4'b0_10_0, 12'b000_000_000_000);
        add(6'b001100, 4'b0_10_0, 12'b000_000_000_000);
        add(6'b000000, 4'b0_10_1, 12'b000_000_000_000);
        // Routing to chain 2.
        add(6'b010011, 4'b0_10_1, 12'b100_100_000_000);
        add(6'b010010, 4'b0_10_1, 12'b000_100_000_000);
        add(6'b010011, 4'b0_10_1, 12'b100_100_000_000);
        add(6'b100010, 4'b0_10_1, 12'b000_000_100_000);
        add(6'b001010, 4'b0_10_1, 12'b000_000_000_100);
        // sel_dr_en overrides routing.
        add(6'b010111, 4'b0_10_1, 12'b000_000_000_000);
        add(6'b100111, 4'b1_10_1, 12'b000_000_000_000);
        add(6'b001110, 4'b0_10_1, 12'b000_000_000_000);
        // Neither enable: everything quiet.
        add(6'b010001, 4'b0_10_1, 12'b000_000_000_000);

        // Reset state while trst_n is held low.
        #2;
        check("reset_hold", 16'h0000);
        @(negedge tck);
        trst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step($sformatf("idle%0d", c), 6'b000000, 16'h0000);
        end

        for (int r = 0; r < tbl.size(); r++) begin
            step($sformatf("row%0d", r), tbl[r].in, {tbl[r].st, tbl[r].vec});
        end

        // Reset mid-shift: capture, one of two bits, then async reset between edges.
        step("mid_cap", 6'b100100, {4'b0_10_1, 12'b0});
        step("mid_sh1", 6'b010101, {4'b0_10_1, 12'b0});
        @(negedge tck);
        drive(6'b010101);
        #2;
        trst_n = 1'b0;
        #1;
        check("async_clear", 16'h0000);
        @(negedge tck);
        trst_n = 1'b1;
        step("post_rst_upd", 6'b001100, 16'h0000);
        step("post_rst_err", 6'b000000, {4'b0_00_1, 12'b0});
        step("route_chain0", 6'b010011, {4'b0_00_1, 12'b001_001_000_000});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bsr_chain_router.md
Name: bsr_chain_router

Overview:
- Scan-in counterpart of the boundary-scan output mux: routes TDI and the TAP's DR control strobes to exactly one of CHAIN_NUM boundary-scan chains.
- Owns the serially loaded chain-select register; its `sel` output drives the select input of the scan-out mux.
- Sits between the TAP controller/instruction decoder and the per-chain BSR cells, clocked by TCK.

Parameters:
- CHAIN_NUM, 2, number of boundary-scan chains (>=1).
- SEL_WIDTH, max(1, $clog2(CHAIN_NUM)), width of the chain-select register.

Ports:
- tck  input  1  JTAG test clock; all state updates on rising edge.
- trst_n  input  1  test reset; asynchronous, active-low.
- tdi  input  1  serial test data in.
- capture_dr  input  1  TAP in Capture-DR (level, one TCK per visit).
- shift_dr  input  1  TAP in Shift-DR.
- update_dr  input  1  TAP in Update-DR.
- sel_dr_en  input  1  CHAIN_SELECT instruction active.
- bsr_dr_en  input  1  boundary-scan instruction active.
- sel_so  output  1  serial out of the select shift register, to the TDO mux.
- sel  output  SEL_WIDTH  active chain index, to the scan-out mux.
- sel_err  output  1  last select update rejected.
- bsr_si  output  CHAIN_NUM  per-chain serial in.
- bsr_shift_en  output  CHAIN_NUM  per-chain shift enable.
- bsr_capture_en  output  CHAIN_NUM  per-chain capture enable.
- bsr_update_en  output  CHAIN_NUM  per-chain update enable.

Behaviour:
- Reset (trst_n=0, async):
  - sel=0, shift register sr=0, bit counter cnt=0, sel_err=0.
  - All per-chain outputs are 0; sel_so=0.
- Select register path (sel_dr_en=1), evaluated on the rising edge of tck:
  - capture_dr: sr<=sel; cnt<=0.
  - shift_dr: sr<={tdi, sr[SEL_WIDTH-1:1]} (LSB first out, new bit into MSB); cnt<=cnt+1, saturating at SEL_WIDTH+1. sel_so=sr[0] combinationally.
  - update_dr: the update is valid only when cnt==SEL_WIDTH and sr<CHAIN_NUM.
    - Valid: sel<=sr and sel_err<=0.
    - Invalid (any other cnt, or sr>=CHAIN_NUM): sel unchanged and sel_err<=1.
  - New sel is visible the cycle after the update_dr edge. sel_err holds until the next update_dr with sel_dr_en=1.
- Routing path (bsr_dr_en=1 and sel_dr_en=0), combinational from the registered sel:
  - bsr_si[i]=tdi when i==sel, else 0.
  - bsr_shift_en[i]=shift_dr & (i==sel); bsr_capture_en and bsr_update_en are decoded the same way from capture_dr and update_dr.
  - At most one bit of each enable vector is high (one-hot or zero).
- Priority: sel_dr_en=1 suppresses all per-chain outputs, even when bsr_dr_en=1. With neither enable high, the block holds state and all per-chain outputs are 0.
- sel_so is 0 whenever sel_dr_en=0.
- CHAIN_NUM=1: SEL_WIDTH=1; only value 0 is accepted and sel is constant 0.
- Simultaneous TAP strobes (illegal from a conforming TAP) are resolved by priority capture > shift > update.
- trst_n asserted mid-shift: immediate clear; the partial select value is discarded.
- Implementation: sel is registered; per-chain outputs are glitch-free combinational decode of registered sel and the TAP levels.

Test Plan:
- CHAIN_NUM=3 (SEL_WIDTH=2). Release trst_n, toggle tck 5 cycles with all enables 0 -> sel=0, sel_err=0, all vectors 3'b000, sel_so=0.
- Set sel to chain 2:
  - Stimulus: sel_dr_en=1; capture; shift 2 bits with tdi=0 then 1; update.
  - Response: sel_so shows 0,0 during shift; sel=2 one cycle after update; sel_err=0.
- Out-of-range value: sel=2, load 3 (tdi=1,1) and update -> sel stays 2, sel_err=1. Then load 1 (tdi=1,0) -> sel=1, sel_err=0.
- Wrong bit count: shift 3 bits (1,0,0) then update -> sel unchanged, sel_err=1. Shift 0 bits then update -> also rejected.
- Routing with sel=2, bsr_dr_en=1, shift_dr=1, tdi toggling 1,0,1:
  - bsr_shift_en=3'b100 and bsr_si[2] follows tdi; bsr_si[1:0]=0.
  - Capture and update pulses appear only on bit 2.
  - Raising sel_dr_en drives all vectors to 0.
- Reset mid-operation: after 1 of 2 select shift bits, drop trst_n between clock edges -> sel=0, cnt=0, sel_err=0 asynchronously. A following update without capture/shift is rejected (sel_err=1, sel=0).
